// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module : game_pkg
// Brief  : Shared screen geometry, pixel type and colour constants.
// Rev    : 1.0
// ============================================================================
package game_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int C_W      = 3;

    localparam logic [C_W-1:0] COL_BLACK = 3'b000;
    localparam logic [C_W-1:0] COL_BLUE  = 3'b001;
    localparam logic [C_W-1:0] COL_GREEN = 3'b010;
    localparam logic [C_W-1:0] COL_RED   = 3'b100;
    localparam logic [C_W-1:0] COL_WHITE = 3'b111;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } pixel_t;

    function automatic logic on_screen(input pixel_t p);
        return (int'(p.x) < SCREEN_W) && (int'(p.y) < SCREEN_H);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_write_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : pixel_write_arbiter_if
// Brief  : Client request bus plus VGA adapter write bus.
// Rev    : 1.0
// ============================================================================
interface pixel_write_arbiter_if #(
    parameter int N_CLIENTS = 4,
    parameter int X_W       = game_pkg::X_W,
    parameter int Y_W       = game_pkg::Y_W,
    parameter int C_W       = game_pkg::C_W
);
    logic [N_CLIENTS-1:0]     req_valid;
    logic [N_CLIENTS*X_W-1:0] req_x;
    logic [N_CLIENTS*Y_W-1:0] req_y;
    logic [N_CLIENTS*C_W-1:0] req_c;
    logic [N_CLIENTS-1:0]     req_ready;
    logic [X_W-1:0]           vga_x;
    logic [Y_W-1:0]           vga_y;
    logic [C_W-1:0]           vga_c;
    logic                     vga_writeEn;

    // master: draw engines and VGA adapter; slave: the arbiter
    modport master (
        output req_valid, req_x, req_y, req_c,
        input  req_ready, vga_x, vga_y, vga_c, vga_writeEn
    );
    modport slave (
        input  req_valid, req_x, req_y, req_c,
        output req_ready, vga_x, vga_y, vga_c, vga_writeEn
    );
endinterface
`default_nettype wire

// File: rtl/pixel_write_arbiter_fifo.sv
`default_nettype none
// ============================================================================
// Module : pixel_fifo
// Brief  : Synchronous FIFO with level output; power-of-two depth.
// Rev    : 1.0
// ============================================================================
module pixel_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 8
) (
    input  wire logic                     clk,
    input  wire logic                     resetn,
    input  wire logic                     push_i,
    input  wire logic [WIDTH-1:0]         wdata_i,
    input  wire logic                     pop_i,
    output logic      [WIDTH-1:0]         rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic      [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      level_q;
    logic             do_push, do_pop;

    assign full_o  = (level_q == (AW+1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    // pointers wrap naturally; the extra level bit separates full from empty
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/pixel_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module : pixel_write_arbiter
// Brief  : Round-robin pixel request arbiter, FIFO and registered VGA write
//          port. Define PIXEL_CLIP_EN to drop off-screen pixels at drain.
// Rev    : 1.0
// ============================================================================
module pixel_write_arbiter #(
    parameter int N_CLIENTS  = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int X_W        = game_pkg::X_W,
    parameter int Y_W        = game_pkg::Y_W,
    parameter int C_W        = game_pkg::C_W
) (
    input  wire logic                          clk,
    input  wire logic                          resetn,
    pixel_write_arbiter_if.slave               bus,
    input  wire logic                          out_en,
    output logic      [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                               busy
);
    localparam int IDX_W = $clog2(N_CLIENTS);
    localparam int E_W   = X_W + Y_W + C_W;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } entry_t;

    logic [IDX_W-1:0] last_q, cand, gnt_idx;
    logic             gnt_any, fifo_full, fifo_empty, pop;
    entry_t           push_data, head, pix_d, pix_q;
    logic             we_d, we_q;

    // search starts one past the last winner so every client gets its turn
    always_comb begin
        gnt_any       = 1'b0;
        gnt_idx       = '0;
        cand          = '0;
        bus.req_ready = '0;
        if (!fifo_full) begin
            for (int k = 1; k <= N_CLIENTS; k++) begin
                cand = IDX_W'((int'(last_q) + k) % N_CLIENTS);
                if (!gnt_any && bus.req_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        if (gnt_any) bus.req_ready[gnt_idx] = 1'b1;
    end

    always_comb begin
        push_data = '0;
        for (int i = 0; i < N_CLIENTS; i++) begin
            if (gnt_idx == IDX_W'(i)) begin
                push_data = '{x: bus.req_x[i*X_W +: X_W],
                              y: bus.req_y[i*Y_W +: Y_W],
                              c: bus.req_c[i*C_W +: C_W]};
            end
        end
    end

    pixel_fifo #(
        .WIDTH (E_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .push_i  (gnt_any),
        .wdata_i (push_data),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level)
    );

    assign pop = out_en && !fifo_empty;

    always_comb begin
        pix_d = pix_q;
        we_d  = 1'b0;
        if (pop) begin
`ifdef PIXEL_CLIP_EN
            // off-screen entries still consume a drain cycle but never reach the bus
            if ((int'(head.x) < game_pkg::SCREEN_W) && (int'(head.y) < game_pkg::SCREEN_H)) begin
                pix_d = head;
                we_d  = 1'b1;
            end
`else
            pix_d = head;
            we_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_q <= IDX_W'(N_CLIENTS - 1);
            pix_q  <= '0;
            we_q   <= 1'b0;
        end else begin
            if (gnt_any) last_q <= gnt_idx;
            pix_q <= pix_d;
            we_q  <= we_d;
        end
    end

    assign bus.vga_x       = pix_q.x;
    assign bus.vga_y       = pix_q.y;
    assign bus.vga_c       = pix_q.c;
    assign bus.vga_writeEn = we_q;
    assign busy            = (fifo_level != '0) || we_q;
endmodule
`default_nettype wire
